// File: rtl/bytecode_fetch.sv
// Bytecode fetch stage: reads 1-3 byte Java bytecode instructions from a
// synchronous-read program memory, issues them to control, and steps the PC.
module bytecode_fetch #(
  parameter int         ADDR_W   = 16,
  parameter logic [7:0] NOP_CODE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] code_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        op_code,
  output logic [7:0]        arg1,
  output logic [7:0]        arg2,
  input  logic [15:0]       offset,
  input  logic              op_done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_OP,
    S_F_A1,
    S_F_A2,
    S_ISSUE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_code_len;
  logic [7:0]        r_op;
  logic [7:0]        r_a1;
  logic [7:0]        r_a2;
  logic [1:0]        r_len;
  logic              r_a2_phase;
  logic              r_busy;
  logic              r_halted;

  logic [1:0]        w_len_dec;
  logic [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_halt;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op)
      8'h10, 8'h12, 8'h15, 8'h36, 8'hBC: len = 2'd2;
      8'h11, 8'h84, 8'hB8:               len = 2'd3;
      default: begin
        if (op >= 8'h99 && op <= 8'hA7) len = 2'd3;
      end
    endcase
    return len;
  endfunction

  assign w_len_dec = op_len(mem_rdata);
  // Branch offsets are relative to the opcode byte; a zero offset means fall-through.
  assign w_off_ext = ADDR_W'($signed(offset));
  assign w_next_pc = (offset != 16'd0) ? (r_pc + w_off_ext) : (r_pc + ADDR_W'(r_len));
  assign w_halt    = (w_next_pc >= r_code_len);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && code_len != '0) w_state_nxt = S_F_OP;
      S_F_OP:  w_state_nxt = S_F_A1;
      S_F_A1:  w_state_nxt = (w_len_dec == 2'd1) ? S_ISSUE : S_F_A2;
      S_F_A2:  if (r_len == 2'd2 || r_a2_phase) w_state_nxt = S_ISSUE;
      S_ISSUE: if (op_done) w_state_nxt = w_halt ? S_IDLE : S_F_OP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_code_len <= '0;
      r_op       <= NOP_CODE;
      r_a1       <= 8'h00;
      r_a2       <= 8'h00;
      r_len      <= 2'd1;
      r_a2_phase <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_code_len <= code_len;
            r_pc       <= '0;
            r_halted   <= (code_len == '0);
            r_busy     <= (code_len != '0);
          end
        end
        S_F_A1: begin
          r_op       <= mem_rdata;
          r_len      <= w_len_dec;
          r_a1       <= 8'h00;
          r_a2       <= 8'h00;
          r_a2_phase <= 1'b0;
        end
        S_F_A2: begin
          if (!r_a2_phase) begin
            r_a1       <= mem_rdata;
            r_a2_phase <= (r_len == 2'd3);
          end else begin
            r_a2       <= mem_rdata;
            r_a2_phase <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (op_done) begin
            if (w_halt) begin
              r_halted <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_pc <= w_next_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand addresses are presented one cycle ahead of the cycle that latches them.
  always_comb begin
    mem_addr = r_pc;
    case (r_state)
      S_F_A1:  mem_addr = r_pc + ADDR_W'(1);
      S_F_A2:  mem_addr = r_pc + ADDR_W'(2);
      default: mem_addr = r_pc;
    endcase
  end

  assign op_code = (r_state == S_ISSUE) ? r_op : NOP_CODE;
  assign arg1    = (r_state == S_ISSUE) ? r_a1 : 8'h00;
  assign arg2    = (r_state == S_ISSUE) ? r_a2 : 8'h00;
  assign pc      = r_pc;
  assign busy    = r_busy;
  assign halted  = r_halted;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Self-checking bench for bytecode_fetch: decode table, directed programs,
// reset corner cases and randomized programs against a trace-level model.
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        rst, start, op_done;
  logic [15:0] code_len, mem_addr, offset, pc;
  logic [7:0]  mem_rdata, op_code, arg1, arg2;
  logic        busy, halted;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  mem [65536];
  logic [7:0]  prog [$];
  logic [15:0] offs [$];
  logic [15:0] e_pc [$];
  logic [7:0]  e_op [$];
  logic [7:0]  e_a1 [$];
  logic [7:0]  e_a2 [$];
  int          e_len [$];

  typedef struct {
    logic [7:0] op;
    logic [7:0] b1;
    logic [7:0] b2;
    int         len;
    logic [7:0] a1;
    logic [7:0] a2;
  } dec_vec_t;

  dec_vec_t tbl [20];
  logic [7:0] pick [12];

  bytecode_fetch dut (
    .clk(clk), .rst(rst), .start(start), .code_len(code_len),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .op_code(op_code),
    .arg1(arg1), .arg2(arg2), .offset(offset), .op_done(op_done),
    .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_len(input logic [7:0] b);
    int u;
    u = int'(b);
    if (b inside {8'h10, 8'h12, 8'h15, 8'h36, 8'hBC}) return 2;
    if (b inside {8'h11, 8'h84, 8'hB8} || (u >= 'h99 && u <= 'hA7)) return 3;
    return 1;
  endfunction

  // Trace of issued instructions, derived from the program bytes and offset list.
  task automatic build_ref(input logic [15:0] L);
    logic [15:0] p, q, o;
    int i, len;
    e_pc.delete(); e_op.delete(); e_a1.delete(); e_a2.delete(); e_len.delete();
    p = 16'd0;
    i = 0;
    while (p < L && i < 400) begin
      len = ref_len(mem[p]);
      e_pc.push_back(p);
      e_op.push_back(mem[p]);
      q = p + 16'd1;
      e_a1.push_back(len >= 2 ? mem[q] : 8'h00);
      q = p + 16'd2;
      e_a2.push_back(len == 3 ? mem[q] : 8'h00);
      e_len.push_back(len);
      o = (i < offs.size()) ? offs[i] : 16'd0;
      if (o != 16'd0) p = p + o;
      else            p = p + 16'(len);
      i++;
    end
  endtask

  task automatic load_prog();
    for (int a = 0; a < 64; a++) mem[a] = 8'h00;
    for (int a = 0; a < prog.size(); a++) mem[a] = prog[a];
  endtask

  // Plays control: checks each expected issue at its exact cycle, then retires it.
  task automatic run_prog(input logic [15:0] L, input int hold, input bit poke);
    int n;
    n = e_op.size();
    code_len = L; start = 1'b1;
    tick();
    start = 1'b0; code_len = 16'($urandom);
    if (L == 16'd0) begin
      chk("len0_halted", halted, 1);
      chk("len0_busy", busy, 0);
      repeat (3) begin
        tick();
        chk("len0_idle_op", op_code, 8'h00);
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      chk("fop_addr", mem_addr, e_pc[i]);
      chk("run_busy", busy, 1);
      chk("run_halted", halted, 0);
      for (int k = 0; k <= e_len[i]; k++) begin
        chk("gap_nop", op_code, 8'h00);
        if (poke) begin op_done = 1'b1; offset = 16'h0040; end
        tick();
        op_done = 1'b0;
      end
      chk("iss_op", op_code, e_op[i]);
      chk("iss_a1", arg1, e_a1[i]);
      chk("iss_a2", arg2, e_a2[i]);
      chk("iss_pc", pc, e_pc[i]);
      for (int h = 0; h < hold; h++) begin
        if (poke && h == 0) begin start = 1'b1; code_len = 16'd0; end
        tick();
        start = 1'b0;
        chk("hold_op", op_code, e_op[i]);
        chk("hold_a1", arg1, e_a1[i]);
        chk("hold_pc", pc, e_pc[i]);
      end
      op_done = 1'b1;
      offset  = (i < offs.size()) ? offs[i] : 16'd0;
      tick();
      op_done = 1'b0;
      offset  = 16'($urandom);
      chk("post_done_nop", op_code, 8'h00);
    end
    chk("end_halted", halted, 1);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    int L, v;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    rst = 1'b1; start = 1'b0; op_done = 1'b0; code_len = 16'd0; offset = 16'd0;

    tbl[0]  = '{8'h00, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    tbl[1]  = '{8'h02, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    tbl[2]  = '{8'h10, 8'h5A, 8'h22, 2, 8'h5A, 8'h00};
    tbl[3]  = '{8'h12, 8'h33, 8'h22, 2, 8'h33, 8'h00};
    tbl[4]  = '{8'h15, 8'h44, 8'h22, 2, 8'h44, 8'h00};
    tbl[5]  = '{8'h36, 8'h55, 8'h22, 2, 8'h55, 8'h00};
    tbl[6]  = '{8'hBC, 8'h0A, 8'h22, 2, 8'h0A, 8'h00};
    tbl[7]  = '{8'h11, 8'h12, 8'h34, 3, 8'h12, 8'h34};
    tbl[8]  = '{8'h84, 8'h01, 8'hFF, 3, 8'h01, 8'hFF};
    tbl[9]  = '{8'h99, 8'h00, 8'h07, 3, 8'h00, 8'h07};
    tbl[10] = '{8'hA0, 8'hAB, 8'hCD, 3, 8'hAB, 8'hCD};
    tbl[11] = '{8'hA6, 8'h01, 8'h02, 3, 8'h01, 8'h02};
    tbl[12] = '{8'hA7, 8'hFF, 8'hF0, 3, 8'hFF, 8'hF0};
    tbl[13] = '{8'hB8, 8'h00, 8'h09, 3, 8'h00, 8'h09};
    tbl[14] = '{8'h98, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    tbl[15] = '{8'hA8, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    tbl[16] = '{8'h13, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    tbl[17] = '{8'hB9, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    tbl[18] = '{8'h37, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    tbl[19] = '{8'hFF, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    pick = '{8'h10, 8'h11, 8'h12, 8'h15, 8'h36, 8'h84, 8'h99, 8'hA7, 8'hB8, 8'hBC, 8'h00, 8'h60};

    // Reset, with an op_done pulse that must be ignored
    tick();
    op_done = 1'b1; offset = 16'h0004;
    tick();
    op_done = 1'b0;
    rst = 1'b0;
    chk("rst_op", op_code, 8'h00);
    chk("rst_a1", arg1, 8'h00);
    chk("rst_a2", arg2, 8'h00);
    chk("rst_pc", pc, 16'd0);
    chk("rst_addr", mem_addr, 16'd0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);

    // Sequential 1-byte program with start/op_done pokes that must be ignored
    prog = '{8'h02, 8'h05, 8'h05, 8'h60, 8'h60}; load_prog();
    offs.delete(); build_ref(16'd5);
    run_prog(16'd5, 3, 1'b1);

    // 2- and 3-byte instructions
    prog = '{8'h10, 8'hFE, 8'h11, 8'h01, 8'h2C}; load_prog();
    offs.delete(); build_ref(16'd5);
    run_prog(16'd5, 3, 1'b0);

    // Forward branch
    prog = '{8'hA7, 8'h00, 8'h03, 8'h00, 8'h02, 8'h00}; load_prog();
    offs = '{16'h0003}; build_ref(16'd5);
    run_prog(16'd5, 2, 1'b0);

    // Backward branch, then wrapping branch that halts
    prog = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA7, 8'h00, 8'h00}; load_prog();
    offs = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFC, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000};
    build_ref(16'd7);
    run_prog(16'd7, 1, 1'b0);

    // Empty program
    offs.delete(); build_ref(16'd0);
    run_prog(16'd0, 0, 1'b0);

    // rst clears halted
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_clr_halted", halted, 0);

    // Reset during ISSUE with a simultaneous op_done
    prog = '{8'h02, 8'h05, 8'h05, 8'h60, 8'h60}; load_prog();
    code_len = 16'd5; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("pre_rst_issue_op", op_code, 8'h02);
    rst = 1'b1; op_done = 1'b1; offset = 16'h0003;
    tick();
    rst = 1'b0; op_done = 1'b0;
    chk("rst_iss_pc", pc, 16'd0);
    chk("rst_iss_op", op_code, 8'h00);
    chk("rst_iss_busy", busy, 0);

    // Reset during F_A2 of a 3-byte instruction, then restart
    prog = '{8'hB8, 8'h12, 8'h34, 8'h05}; load_prog();
    code_len = 16'd4; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    chk("rst_fa2_busy", busy, 0);
    chk("rst_fa2_pc", pc, 16'd0);
    repeat (5) begin
      chk("rst_fa2_idle_op", op_code, 8'h00);
      tick();
    end
    offs.delete(); build_ref(16'd4);
    run_prog(16'd4, 1, 1'b0);

    // Decode table: single-instruction programs
    foreach (tbl[t]) begin
      for (int a = 0; a < 64; a++) mem[a] = 8'h00;
      mem[0] = tbl[t].op; mem[1] = tbl[t].b1; mem[2] = tbl[t].b2;
      e_pc = '{16'd0}; e_op = '{tbl[t].op}; e_a1 = '{tbl[t].a1};
      e_a2 = '{tbl[t].a2}; e_len = '{tbl[t].len};
      offs.delete();
      run_prog(16'd1, 1, 1'b0);
    end

    // Randomized programs and branch offsets
    for (int r = 0; r < 30; r++) begin
      L = $urandom_range(1, 24);
      for (int a = 0; a < 64; a++)
        mem[a] = ($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 11)] : 8'($urandom);
      offs.delete();
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          v = $urandom_range(0, 14) - 6;
          offs.push_back(16'(v));
        end else if ($urandom_range(0, 15) == 0) begin
          offs.push_back(16'h8000);
        end else begin
          offs.push_back(16'h0000);
        end
      end
      build_ref(16'(L));
      run_prog(16'(L), $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bytecode_fetch.md
Name: bytecode_fetch

Overview:
- Instruction fetch stage directly upstream of `control`.
- Reads Java bytecode from a synchronous-read program memory and decodes the instruction length (1–3 bytes).
- Presents `op_code`/`arg1`/`arg2` to `control` and holds them until `control` pulses `op_done`.
- Uses the returned `offset` to compute the next PC, covering both sequential flow and taken branches.

Parameters:
- ADDR_W, 16, program memory byte-address width and PC width.
- NOP_CODE, 8'h00, opcode driven to `control` whenever no instruction is being issued.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution from PC 0 when idle or halted.
- code_len  input  ADDR_W  number of valid bytecode bytes; sampled on `start`.
- mem_addr  output  ADDR_W  program memory read address.
- mem_rdata  input  8  program memory read data; valid one cycle after `mem_addr`.
- op_code  output  8  opcode to `control`.
- arg1  output  8  first operand byte, or 0 if absent.
- arg2  output  8  second operand byte, or 0 if absent.
- offset  input  16  signed PC delta from `control`, relative to the opcode address; sampled with `op_done`.
- op_done  input  1  one-cycle pulse from `control`: current instruction is retired.
- pc  output  ADDR_W  address of the current instruction's opcode byte.
- busy  output  1  high from `start` until halt.
- halted  output  1  high once the PC leaves `[0, code_len)`; cleared by `start` or `rst`.

Behaviour:
- Reset values (`rst`=1, any state): state=IDLE, pc=0, mem_addr=0, op_code=NOP_CODE, arg1=0, arg2=0, busy=0, halted=0. Reset mid-fetch or mid-issue abandons the instruction and ignores `op_done` in that cycle.
- States: IDLE, F_OP, F_A1, F_A2, ISSUE.
- IDLE: `start` latches `code_len`, sets pc=0 and busy=1, clears halted, goes to F_OP. If `code_len`=0: halted=1, busy=0, stay IDLE.
- F_OP: mem_addr=pc; next state F_A1.
- F_A1:
  - Latch opcode from `mem_rdata`.
  - Decode length: 2 bytes for 10,12,15,36,BC; 3 bytes for 11,84,99–A6,A7,B8; all other opcodes 1 byte.
  - Length 1: go to ISSUE.
  - Length 2 or 3: mem_addr=pc+1, go to F_A2.
- F_A2: latch arg1. Length 2: go to ISSUE. Length 3: mem_addr=pc+2, stay one more cycle, latch arg2, then go to ISSUE. A sub-flag distinguishes the two arg cycles.
- Unfetched args read 0.
- Operand bytes beyond `code_len` are still fetched; no bounds check applies mid-instruction.
- ISSUE: drive the latched op_code/arg1/arg2, stable every cycle until `op_done`. Outside ISSUE, op_code=NOP_CODE.
- On `op_done` in ISSUE, compute next_pc:
  - offset ≠ 0: next_pc = pc + sign-extended offset, modulo 2^ADDR_W.
  - offset = 0: next_pc = pc + length. A self-jump (goto 0) is therefore not supported.
  - If next_pc ≥ latched code_len (unsigned): halted=1, busy=0, go to IDLE.
  - Otherwise pc=next_pc, go to F_OP.
- In all cases op_code returns to NOP_CODE in the cycle after `op_done`.
- Latency from entering F_OP to first ISSUE cycle: 2 cycles for 1-byte, 3 for 2-byte, 4 for 3-byte instructions.
- Ignored inputs:
  - `op_done` outside ISSUE.
  - `start` while busy.
  - Simultaneous `rst` and `start`: `rst` wins.

Test Plan:
- Reset: assert `rst` 2 cycles → op_code=00, pc=0, busy=0, halted=0; an `op_done` pulse during reset has no effect.
- Memory {02,05,05,60,60}, code_len=5, `control` replies offset=0 with `op_done` 3 cycles into each ISSUE → op_codes issued in order 02,05,05,60,60 with pc 0,1,2,3,4; then halted=1, busy=0.
- Memory {10,FE,11,01,2C}, code_len=5, offset=0 → issues (10,FE,00) at pc 0 and (11,01,2C) at pc 2; F_OP→ISSUE gaps of 3 and 4 cycles.
- Memory {A7,00,03,00,02,00}, first `op_done` offset=16'h0003 → next pc=3; issues 00 then 02; then halted.
- Backward branch: at pc=4 (opcode A7), offset=16'hFFFC → pc=0, fetch restarts at 0. Offset 16'h8000 at pc=4 → wraps to 16'h8004 ≥ code_len → halted.
- Assert `rst` during F_A2 of a 3-byte instruction → next cycle state IDLE, op_code=00; a fresh `start` refetches from pc 0 correctly.
